fetch_queue: RTL

Parametrised instruction-fetch front end; successor to the single-register program counter and one-shot instruction memory read. Owns the fetch PC, issues word reads to instruction memory through a MOV/MOC handshake that tolerates multi-cycle latency, and buffers fetched words with their PCs in a DEPTH-entry prefetch FIFO. Sits between instruction memory and the decode/control stage, and flushes and redirects on jump or branch.

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle for the instruction-fetch front end: redirect port,
// MOV/MOC memory read channel and the decode-side instruction stream.
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              MOV;
  logic [ADDR_W-1:0] mem_addr;
  logic              MOC;
  logic [DATA_W-1:0] mem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] Instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic [CNT_W-1:0]  count;

  // The fetch queue itself
  modport master (
    input  redirect, redirect_pc, MOC, mem_data, instr_ready,
    output MOV, mem_addr, instr_valid, Instruction, instr_pc, count
  );

  // Memory plus decode stage surrounding the fetch queue
  modport slave (
    output redirect, redirect_pc, MOC, mem_data, instr_ready,
    input  MOV, mem_addr, instr_valid, Instruction, instr_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// word read at a time over MOV/MOC, and buffers returned words together
// with their PCs in a DEPTH-entry prefetch FIFO. A redirect flushes the
// FIFO; an in-flight read is never aborted, its data is simply dropped.
module fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              mov_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] target;
  logic              push;
  logic              pop;
  logic              flush;

  // Low two bits of a redirect target are forced to zero (word alignment)
  assign target = bus.redirect_pc & ~ADDR_W'(3);
  assign flush  = bus.redirect;
  assign push   = (state_q == WAIT) && bus.MOC && !bus.redirect;
  assign pop    = (count_q != '0) && bus.instr_ready;

  assign bus.MOV         = mov_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.count       = count_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.Instruction = data_mem_q[rd_ptr_q];
  assign bus.instr_pc    = pc_mem_q[rd_ptr_q];

  // Fetch FSM: request issue, wait for completion, or drain a stale read
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mov_q      <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc_q <= target;
          end else if (count_q < FULL_CNT) begin
            mov_q      <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.MOC) begin
            mov_q      <= 1'b0;
            state_q    <= IDLE;
            fetch_pc_q <= bus.redirect ? target : fetch_pc_q + ADDR_W'(4);
          end else if (bus.redirect) begin
            fetch_pc_q <= target;
            state_q    <= DROP;
          end
        end
        DROP: begin
          if (bus.redirect) begin
            fetch_pc_q <= target;
          end
          if (bus.MOC) begin
            mov_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          mov_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointer/occupancy next state; a flush wins over any pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // FIFO registers and storage; storage is cleared so the head is never X
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        data_mem_q[wr_ptr_q] <= bus.mem_data;
      end
    end
  end
endmodule
